// File: rtl/player_step_ctrl_pkg.sv
// Shared definitions for the player step controller: tile ids, direction bits,
// FSM state encoding and position width.
package player_step_ctrl_pkg;

    localparam int unsigned TILE_FLOOR = 0;
    localparam int unsigned TILE_WALL  = 1;
    localparam int unsigned TILE_KEY   = 2;
    localparam int unsigned TILE_DOOR  = 3;
    localparam int unsigned TILE_EXIT  = 4;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    localparam int POS_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DECIDE,
        ST_WRITE,
        ST_ACK
    } step_state_e;

endpackage

// File: rtl/player_step_ctrl_if.sv
// Request/acknowledge handshake with btn_reg plus the map BRAM port B bus.
// The controller uses the master modport; the request source and BRAM use slave.
interface player_step_ctrl_if #(
    parameter int ADDR_W = 19,
    parameter int TILE_W = 16
);
    logic [3:0]        move_req;
    logic              move_ack;
    logic              busy;
    logic [ADDR_W-1:0] map_addr;
    logic [TILE_W-1:0] map_dout;
    logic [TILE_W-1:0] map_din;
    logic              map_we;

    modport master (
        input  move_req,
        input  map_dout,
        output move_ack,
        output busy,
        output map_addr,
        output map_din,
        output map_we
    );

    modport slave (
        output move_req,
        output map_dout,
        input  move_ack,
        input  busy,
        input  map_addr,
        input  map_din,
        input  map_we
    );
endinterface

// File: rtl/player_step_ctrl_step_target_calc.sv
// Combinational target-tile calculator: picks one direction (up>down>left>right),
// returns the neighbouring tile, whether it lies on the map, and its BRAM address.
module step_target_calc
    import player_step_ctrl_pkg::*;
#(
    parameter int MAP_WIDTH  = 13,
    parameter int MAP_HEIGHT = 13,
    parameter int ADDR_W     = 19
) (
    input  logic [3:0]        dir,
    input  logic [POS_W-1:0]  pos_x,
    input  logic [POS_W-1:0]  pos_y,
    output logic [POS_W-1:0]  tx,
    output logic [POS_W-1:0]  ty,
    output logic              in_bounds,
    output logic [ADDR_W-1:0] addr
);

    always_comb begin
        tx        = pos_x;
        ty        = pos_y;
        in_bounds = 1'b0;
        if (dir[DIR_UP]) begin
            in_bounds = (pos_y != '0);
            ty        = pos_y - POS_W'(1);
        end else if (dir[DIR_DOWN]) begin
            in_bounds = (pos_y != POS_W'(MAP_HEIGHT - 1));
            ty        = pos_y + POS_W'(1);
        end else if (dir[DIR_LEFT]) begin
            in_bounds = (pos_x != '0);
            tx        = pos_x - POS_W'(1);
        end else if (dir[DIR_RIGHT]) begin
            in_bounds = (pos_x != POS_W'(MAP_WIDTH - 1));
            tx        = pos_x + POS_W'(1);
        end
    end

    assign addr = ADDR_W'(ty) * ADDR_W'(MAP_WIDTH) + ADDR_W'(tx);

endmodule

// File: rtl/player_step_ctrl.sv
// Resolves one player step: reads the target tile, applies the game rules,
// updates position/keys and optionally clears the tile back to floor.
module player_step_ctrl
    import player_step_ctrl_pkg::*;
#(
    parameter int MAP_WIDTH  = 13,
    parameter int MAP_HEIGHT = 13,
    parameter int ADDR_W     = 19,
    parameter int TILE_W     = 16,
    parameter int KEY_W      = 4,
    parameter int START_X    = 6,
    parameter int START_Y    = 11
) (
    input  logic               clk,
    input  logic               rstn,
    player_step_ctrl_if.master bus,
    output logic [POS_W-1:0]   player_x,
    output logic [POS_W-1:0]   player_y,
    output logic [KEY_W-1:0]   key_cnt,
    output logic               level_done
);

    step_state_e       state_q, state_d;
    logic [POS_W-1:0]  px_q, px_d, py_q, py_d;
    logic [POS_W-1:0]  tx_q, tx_d, ty_q, ty_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TILE_W-1:0] din_q, din_d;

    logic [POS_W-1:0]  calc_tx, calc_ty;
    logic              calc_in_bounds;
    logic [ADDR_W-1:0] calc_addr;

    step_target_calc #(
        .MAP_WIDTH (MAP_WIDTH),
        .MAP_HEIGHT(MAP_HEIGHT),
        .ADDR_W    (ADDR_W)
    ) u_target (
        .dir      (bus.move_req),
        .pos_x    (px_q),
        .pos_y    (py_q),
        .tx       (calc_tx),
        .ty       (calc_ty),
        .in_bounds(calc_in_bounds),
        .addr     (calc_addr)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            px_q    <= POS_W'(START_X);
            py_q    <= POS_W'(START_Y);
            tx_q    <= '0;
            ty_q    <= '0;
            key_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            key_q   <= key_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        px_d       = px_q;
        py_d       = py_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        key_d      = key_q;
        addr_d     = addr_q;
        din_d      = din_q;
        level_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.move_req != '0) begin
                    tx_d = calc_tx;
                    ty_d = calc_ty;
                    if (calc_in_bounds) begin
                        addr_d  = calc_addr;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: state_d = ST_DECIDE;
            ST_DECIDE: begin
                state_d = ST_ACK;
                // Unknown tile ids fall through to the default and block like a wall.
                case (bus.map_dout)
                    TILE_W'(TILE_FLOOR): begin
                        px_d = tx_q;
                        py_d = ty_q;
                    end
                    TILE_W'(TILE_KEY): begin
                        px_d    = tx_q;
                        py_d    = ty_q;
                        key_d   = (key_q == '1) ? key_q : key_q + KEY_W'(1);
                        din_d   = TILE_W'(TILE_FLOOR);
                        state_d = ST_WRITE;
                    end
                    TILE_W'(TILE_DOOR): begin
                        if (key_q != '0) begin
                            key_d   = key_q - KEY_W'(1);
                            din_d   = TILE_W'(TILE_FLOOR);
                            state_d = ST_WRITE;
                        end
                    end
                    TILE_W'(TILE_EXIT): begin
                        px_d       = tx_q;
                        py_d       = ty_q;
                        level_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_WRITE: state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign bus.move_ack = (state_q == ST_ACK);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.map_we   = (state_q == ST_WRITE);
    assign bus.map_addr = addr_q;
    assign bus.map_din  = din_q;

    assign player_x = px_q;
    assign player_y = py_q;
    assign key_cnt  = key_q;

endmodule
